// File: rtl/board_uart_rx_if.sv
// Serial-in / packed-board-out bundle for board_uart_rx.
// The slave modport is the receiver's view. The master modport is the line driver and board consumer.
interface board_uart_rx_if;
    logic         rx_in;
    logic [161:0] board_out;
    logic         board_valid;
    logic         frame_err;
    logic         timeout;
    logic         busy;

    modport master (output rx_in, input board_out, board_valid, frame_err, timeout, busy);
    modport slave  (input rx_in, output board_out, board_valid, frame_err, timeout, busy);
endinterface

// File: rtl/board_uart_rx.sv
// board_uart_rx: 8N1 UART receiver that assembles 21 bytes into a packed 9x9 board.
// Byte j carries cells 4j..4j+3. Cell k is placed at board_out[2k+1:2k].
// The last byte contributes only its two low bits, and its pad bits are ignored.
// Optional feature macro: BOARD_RX_TIMEOUT_EN abandons a partial board after
// TIMEOUT_BITS idle bit-times. When the macro is undefined, timeout is tied low.
module board_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 21,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    board_uart_rx_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SW = 8 * (NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t          state_q,   state_d;
    logic [1:0]      rx_sync_q;
    logic            rx_s;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q,   shift_d;
    logic [4:0]      byte_cnt_q, byte_cnt_d;
    logic [SW-1:0]   shadow_q,  shadow_d;
    logic [SW+1:0]   board_q,   board_d;
    logic            valid_q,   valid_d;
    logic            ferr_q,    ferr_d;
    logic            busy_q,    busy_d;

`ifdef BOARD_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            tout_q,     tout_d;
`endif

    assign rx_s = rx_sync_q[1];

    // State, counters, datapath and registered outputs; reset returns everything to idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            rx_sync_q  <= 2'b11;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            byte_cnt_q <= 5'd0;
            shadow_q   <= '0;
            board_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef BOARD_RX_TIMEOUT_EN
            idle_cnt_q <= '0;
            tout_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_sync_q  <= {rx_sync_q[0], bus.rx_in};
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            board_q    <= board_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
`ifdef BOARD_RX_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
            tout_q     <= tout_d;
`endif
        end
    end

    // Next-state logic: bit timing, byte assembly, board commit and error handling.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        board_d    = board_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef BOARD_RX_TIMEOUT_EN
        idle_cnt_d = '0;
        tout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = '0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;      // glitch, not a real start bit
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};   // LSB arrives first
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        if (byte_cnt_q == 5'(NUM_BYTES - 1)) begin
                            board_d    = {shift_q[1:0], shadow_q};
                            valid_d    = 1'b1;
                            byte_cnt_d = 5'd0;
                            shadow_d   = '0;
                        end else begin
                            for (int j = 0; j < NUM_BYTES - 1; j++) begin
                                if (byte_cnt_q == 5'(j)) begin
                                    shadow_d[8*j +: 8] = shift_q;
                                end else begin
                                    shadow_d[8*j +: 8] = shadow_d[8*j +: 8];
                                end
                            end
                            byte_cnt_d = byte_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d    = ST_WAIT_HIGH;
                        ferr_d     = 1'b1;
                        byte_cnt_d = 5'd0;
                        shadow_d   = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;      // a stuck-low line must not look like a start bit
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef BOARD_RX_TIMEOUT_EN
        // A start edge takes priority and clears the idle count.
        if ((state_q == ST_IDLE) && rx_s && (byte_cnt_q != 5'd0)) begin
            if (idle_cnt_q == TW'(TO_LIMIT - 1)) begin
                tout_d     = 1'b1;
                byte_cnt_d = 5'd0;
                shadow_d   = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + TW'(1);
            end
        end else begin
            idle_cnt_d = '0;
        end
`endif
        busy_d = (byte_cnt_d != 5'd0) || (state_d != ST_IDLE);
    end

    assign bus.board_out   = board_q;
    assign bus.board_valid = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.busy        = busy_q;
`ifdef BOARD_RX_TIMEOUT_EN
    assign bus.timeout     = tout_q;
`else
    assign bus.timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_board_uart_rx.sv
// Directed and randomized bench for board_uart_rx (CLKS_PER_BIT=16, TIMEOUT_BITS=4).
// The expected board is rebuilt from the transmitted byte list using cell arithmetic.
module tb_board_uart_rx;
    localparam int CPB = 16;

    logic clk;
    logic rst_in;
    board_uart_rx_if bus ();

    board_uart_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(21), .TIMEOUT_BITS(4)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           valid_cnt = 0;
    int           ferr_cnt = 0;
    int           tout_cnt = 0;
    int           tout_cyc = 0;
    int           overlap_cnt = 0;
    bit           any_nz = 1'b0;
    logic [7:0]   tx_bytes [21];
    logic [161:0] exp_board;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (bus.board_valid) valid_cnt = valid_cnt + 1;
        if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
        if (bus.timeout) begin
            tout_cnt = tout_cnt + 1;
            tout_cyc = cyc;
        end
        if (bus.board_valid && (bus.frame_err || bus.timeout)) overlap_cnt = overlap_cnt + 1;
        if (bus.board_valid || bus.frame_err || bus.timeout || bus.busy || (bus.board_out != '0))
            any_nz = 1'b1;
    end

    function automatic logic [161:0] model_board();
        logic [161:0] r;
        r = '0;
        for (int k = 0; k < 81; k++) begin
            r[2*k +: 2] = tx_bytes[k / 4][2*(k % 4) +: 2];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx_in = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = b[i];
            wait_cycles(CPB);
        end
        bus.rx_in = stop_bit;
        wait_cycles(CPB);
    endtask

    task automatic send_board();
        for (int j = 0; j < 21; j++) send_byte(tx_bytes[j], 1'b1);
    endtask

    task automatic random_bytes();
        for (int j = 0; j < 21; j++) tx_bytes[j] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int v0;
        int f0;
        int t0;
        int end_cyc;
        rst_in = 1'b1;
        bus.rx_in = 1'b1;
        exp_board = '0;
        wait_cycles(5);
        rst_in = 1'b0;
        wait_cycles(1);

        // Reset values.
        check("rst_board_out", bus.board_out, 162'd0);
        check("rst_valid", 162'(bus.board_valid), 162'd0);
        check("rst_frame_err", 162'(bus.frame_err), 162'd0);
        check("rst_timeout", 162'(bus.timeout), 162'd0);
        check("rst_busy", 162'(bus.busy), 162'd0);

        // Idle line for 1000 cycles: nothing moves.
        any_nz = 1'b0;
        wait_cycles(1000);
        check("idle_quiet", 162'(any_nz), 162'd0);

        // Directed board: byte j = j*0x0B, last byte 0x03.
        for (int j = 0; j < 20; j++) tx_bytes[j] = 8'(j * 11);
        tx_bytes[20] = 8'h03;
        v0 = valid_cnt;
        send_board();
        wait_cycles(2 * CPB);
        exp_board = model_board();
        check("dir_valid_pulses", 162'(valid_cnt - v0), 162'd1);
        check("dir_board", bus.board_out, exp_board);
        check("dir_byte0", 162'(bus.board_out[7:0]), 162'h00);
        check("dir_byte1", 162'(bus.board_out[15:8]), 162'h0B);
        check("dir_cell80", 162'(bus.board_out[161:160]), 162'd3);
        check("dir_busy_after", 162'(bus.busy), 162'd0);

        // Random boards, including random pad bits in the last byte.
        for (int r = 0; r < 2; r++) begin
            random_bytes();
            v0 = valid_cnt;
            send_board();
            wait_cycles(2 * CPB);
            exp_board = model_board();
            check("rnd_valid_pulses", 162'(valid_cnt - v0), 162'd1);
            check("rnd_board", bus.board_out, exp_board);
        end

        // Framing error on byte 5, line held low, then a good board.
        random_bytes();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int j = 0; j < 5; j++) send_byte(tx_bytes[j], 1'b1);
        send_byte(tx_bytes[5], 1'b0);
        wait_cycles(40);
        bus.rx_in = 1'b1;
        wait_cycles(2 * CPB);
        check("ferr_pulses", 162'(ferr_cnt - f0), 162'd1);
        check("ferr_no_valid", 162'(valid_cnt - v0), 162'd0);
        check("ferr_board_held", bus.board_out, exp_board);
        check("ferr_busy", 162'(bus.busy), 162'd0);
        random_bytes();
        v0 = valid_cnt;
        send_board();
        wait_cycles(2 * CPB);
        exp_board = model_board();
        check("ferr_next_valid", 162'(valid_cnt - v0), 162'd1);
        check("ferr_next_board", bus.board_out, exp_board);

        // One-cycle low glitch on an idle line.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        bus.rx_in = 1'b0;
        wait_cycles(1);
        bus.rx_in = 1'b1;
        wait_cycles(3 * CPB);
        check("glitch_no_ferr", 162'(ferr_cnt - f0), 162'd0);
        check("glitch_no_valid", 162'(valid_cnt - v0), 162'd0);
        check("glitch_busy", 162'(bus.busy), 162'd0);
        random_bytes();
        send_board();
        wait_cycles(2 * CPB);
        exp_board = model_board();
        check("glitch_next_valid", 162'(valid_cnt - v0), 162'd1);
        check("glitch_next_board", bus.board_out, exp_board);

        // Ten bytes, then an 80-cycle idle gap.
        random_bytes();
        t0 = tout_cnt;
        v0 = valid_cnt;
        for (int j = 0; j < 10; j++) send_byte(tx_bytes[j], 1'b1);
        end_cyc = cyc;
        wait_cycles(80);
`ifdef BOARD_RX_TIMEOUT_EN
        check("tout_pulses", 162'(tout_cnt - t0), 162'd1);
        check("tout_timing_ok",
              162'(((tout_cyc - end_cyc) >= 52) && ((tout_cyc - end_cyc) <= 66)), 162'd1);
        check("tout_busy", 162'(bus.busy), 162'd0);
        check("tout_board_held", bus.board_out, exp_board);
        random_bytes();
        send_board();
        wait_cycles(2 * CPB);
        exp_board = model_board();
        check("tout_next_valid", 162'(valid_cnt - v0), 162'd1);
        check("tout_next_board", bus.board_out, exp_board);
`else
        check("notout_pulses", 162'(tout_cnt - t0), 162'd0);
        check("notout_busy", 162'(bus.busy), 162'd1);
        check("notout_board_held", bus.board_out, exp_board);
`endif

        // Reset asserted in the middle of byte 12.
        random_bytes();
        for (int j = 0; j < 12; j++) send_byte(tx_bytes[j], 1'b1);
        bus.rx_in = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 3; i++) begin
            bus.rx_in = tx_bytes[12][i];
            wait_cycles(CPB);
        end
        rst_in = 1'b1;
        wait_cycles(1);
        check("midrst_board_out", bus.board_out, 162'd0);
        check("midrst_busy", 162'(bus.busy), 162'd0);
        rst_in = 1'b0;
        bus.rx_in = 1'b1;
        wait_cycles(2 * CPB);
        random_bytes();
        v0 = valid_cnt;
        send_board();
        wait_cycles(2 * CPB);
        exp_board = model_board();
        check("midrst_next_valid", 162'(valid_cnt - v0), 162'd1);
        check("midrst_next_board", bus.board_out, exp_board);

        check("pulse_exclusive", 162'(overlap_cnt), 162'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
